// File: rtl/mem_check_responder.sv
// Memory responder with expected-store checker for core bring-up.
// Optional MEMCHK_ANY_ORDER_EN: stores may match expected entries in any order.
module mem_check_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int CHECK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_valid,
  input  logic                           mem_instr,
  input  logic [31:0]                    mem_addr,
  input  logic [31:0]                    mem_wdata,
  input  logic [3:0]                     mem_wstrb,
  output logic                           mem_ready,
  output logic [31:0]                    mem_rdata,
  input  logic                           ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0]   ld_idx,
  input  logic [31:0]                    ld_data,
  input  logic                           chk_en,
  input  logic [$clog2(CHECK_DEPTH)-1:0] chk_idx,
  input  logic [31:0]                    chk_addr,
  input  logic [31:0]                    chk_data,
  output logic [15:0]                    pass_count,
  output logic [15:0]                    error_count,
  output logic [15:0]                    oob_count,
  output logic                           chk_done
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(CHECK_DEPTH);
  localparam logic [31:0] MW = 32'(MEM_WORDS);
  localparam logic [31:0] WLAST =
    (WAIT_CYCLES > 0) ? 32'(WAIT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]            r_wcnt;
  logic [31:0]            r_mem   [MEM_WORDS];
  logic [31:0]            r_rdata;
  logic [31:0]            r_caddr [CHECK_DEPTH];
  logic [31:0]            r_cdata [CHECK_DEPTH];
  logic [CHECK_DEPTH-1:0] r_valid;
  logic [CHECK_DEPTH-1:0] r_cons;
  logic [15:0]            r_pass;
  logic [15:0]            r_err;
  logic [15:0]            r_oob;

  logic          w_accept;
  logic          w_inrange;
  logic          w_is_wr;
  logic          w_chk;
  logic          w_wr_ok;
  logic [AW-1:0] w_idx;
  logic          w_hit;
  logic [CW-1:0] w_hit_idx;
  logic          w_unused;

  assign w_accept  = !reset && (r_state == S_IDLE) && mem_valid;
  assign w_inrange = ({2'b00, mem_addr[31:2]} < MW);
  assign w_idx     = mem_addr[AW+1:2];
  assign w_is_wr   = |mem_wstrb;
  assign w_chk     = w_accept && (mem_wstrb == 4'hF);
  // A preload to the same word in the same cycle wins over the core write
  assign w_wr_ok   = w_accept && w_inrange && w_is_wr &&
                     !(ld_en && (ld_idx == w_idx));
  assign w_unused  = mem_instr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register and wait-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 32'd1;
      else                   r_wcnt <= '0;
    end
  end

  // Next-state: accept in IDLE, hold WAIT_CYCLES cycles, one RESP cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_valid)
          w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_wcnt == WLAST) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Response outputs: data only shown alongside the ready pulse
  always_comb begin
    mem_ready = (r_state == S_RESP);
    mem_rdata = mem_ready ? r_rdata : 32'd0;
  end

  // Capture read data at the acceptance edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_accept) begin
      r_rdata <= (w_inrange && !w_is_wr) ? r_mem[w_idx] : 32'd0;
    end
  end

  // Memory array: preload port and strobed core writes, never cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_en) r_mem[ld_idx] <= ld_data;
      if (w_wr_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b])
            r_mem[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef MEMCHK_ANY_ORDER_EN
  // Find the lowest valid unconsumed entry matching this store
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = CHECK_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && !r_cons[i] &&
          (r_caddr[i] == mem_addr) &&
          (r_cdata[i] == mem_wdata)) begin
        w_hit     = 1'b1;
        w_hit_idx = CW'(i);
      end
    end
  end
`else
  logic          w_has;
  logic [CW-1:0] w_head;

  // Compare only against the lowest valid unconsumed entry
  always_comb begin
    w_has  = 1'b0;
    w_head = '0;
    for (int i = CHECK_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && !r_cons[i]) begin
        w_has  = 1'b1;
        w_head = CW'(i);
      end
    end
    w_hit     = w_has &&
                (r_caddr[w_head] == mem_addr) &&
                (r_cdata[w_head] == mem_wdata);
    w_hit_idx = w_head;
  end
`endif

  // Checker state; a table load in the same cycle overrides consumption
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_cons  <= '0;
      r_pass  <= '0;
      r_err   <= '0;
      r_oob   <= '0;
    end else begin
      if (w_chk) begin
        if (w_hit) begin
          r_pass            <= sat_inc(r_pass);
          r_cons[w_hit_idx] <= 1'b1;
        end else begin
          r_err <= sat_inc(r_err);
        end
      end
      if (w_accept && !w_inrange) r_oob <= sat_inc(r_oob);
      if (chk_en) begin
        r_valid[chk_idx] <= 1'b1;
        r_cons[chk_idx]  <= 1'b0;
      end
    end
  end

  // Expected-store table contents
  always_ff @(posedge clk) begin
    if (!reset && chk_en) begin
      r_caddr[chk_idx] <= chk_addr;
      r_cdata[chk_idx] <= chk_data;
    end
  end

  assign pass_count  = r_pass;
  assign error_count = r_err;
  assign oob_count   = r_oob;
  assign chk_done    = (|r_valid) && ((r_valid & ~r_cons) == '0);

endmodule

// File: tb/tb_mem_check_responder.sv
// Directed bench for mem_check_responder.
// Two instances: WAIT_CYCLES=0 and WAIT_CYCLES=3.
module tb_mem_check_responder;

  logic        clk;
  logic        reset;
  logic        instr;
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;
  logic        chk_en;
  logic [2:0]  chk_idx;
  logic [31:0] chk_addr;
  logic [31:0] chk_data;

  logic        v0, rdy0, done0;
  logic [31:0] a0, d0, rd0;
  logic [3:0]  s0;
  logic [15:0] pass0, err0, oob0;

  logic        v3, rdy3, done3;
  logic [31:0] a3, d3, rd3;
  logic [3:0]  s3;
  logic [15:0] pass3, err3, oob3;

  int ntests;
  int nfail;

  logic [31:0] rd;
  logic        seen;

  mem_check_responder #(
    .MEM_WORDS(1024), .WAIT_CYCLES(0), .CHECK_DEPTH(8)
  ) u0 (
    .clk(clk), .reset(reset),
    .mem_valid(v0), .mem_instr(instr),
    .mem_addr(a0), .mem_wdata(d0), .mem_wstrb(s0),
    .mem_ready(rdy0), .mem_rdata(rd0),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .chk_en(chk_en), .chk_idx(chk_idx),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .pass_count(pass0), .error_count(err0),
    .oob_count(oob0), .chk_done(done0)
  );

  mem_check_responder #(
    .MEM_WORDS(1024), .WAIT_CYCLES(3), .CHECK_DEPTH(8)
  ) u3 (
    .clk(clk), .reset(reset),
    .mem_valid(v3), .mem_instr(instr),
    .mem_addr(a3), .mem_wdata(d3), .mem_wstrb(s3),
    .mem_ready(rdy3), .mem_rdata(rd3),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .chk_en(chk_en), .chk_idx(chk_idx),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .pass_count(pass3), .error_count(err3),
    .oob_count(oob3), .chk_done(done3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [9:0] idx,
                         input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic chk_load(input logic [2:0] idx,
                          input logic [31:0] addr,
                          input logic [31:0] data);
    @(negedge clk);
    chk_en = 1'b1; chk_idx = idx;
    chk_addr = addr; chk_data = data;
    @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic req0(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rdata);
    @(negedge clk);
    v0 = 1'b1; a0 = a; d0 = d; s0 = s;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk({tag, "_ready"}, 32'(rdy0), 32'd1);
    rdata = rd0;
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(rdy0), 32'd0);
  endtask

  task automatic req3(input string tag,
                      input logic [31:0] a,
                      input int exp_lat,
                      input logic [31:0] exp_rd);
    int lat;
    logic [31:0] r;
    lat = 0;
    r = '0;
    @(negedge clk);
    v3 = 1'b1; a3 = a; d3 = '0; s3 = 4'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      if (rdy3) begin
        lat = k;
        r = rd3;
        break;
      end
      v3 = ~v3;
      a3 = 32'h8;
      @(posedge clk); #1;
    end
    v3 = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, r, exp_rd);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(rdy3), 32'd0);
  endtask

  initial begin
    ntests = 0; nfail = 0;
    clk = 1'b0; reset = 1'b1; instr = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    chk_en = 1'b0; chk_idx = '0; chk_addr = '0; chk_data = '0;
    v0 = 1'b0; a0 = '0; d0 = '0; s0 = '0;
    v3 = 1'b0; a3 = '0; d3 = '0; s3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready",  32'(rdy0),  32'd0);
    chk("rst_rdata",  rd0,        32'd0);
    chk("rst_pass",   32'(pass0), 32'd0);
    chk("rst_err",    32'(err0),  32'd0);
    chk("rst_oob",    32'(oob0),  32'd0);
    chk("rst_done",   32'(done0), 32'd0);
    chk("rst_ready3", 32'(rdy3),  32'd0);

    // Reset beats preload and table load in the same cycle
    preload(10'd5, 32'h1111_1111);
    @(negedge clk);
    reset = 1'b1;
    ld_en = 1'b1; ld_idx = 10'd5; ld_data = 32'h2222_2222;
    chk_en = 1'b1; chk_idx = 3'd0;
    chk_addr = 32'h1C; chk_data = 32'h7E4;
    @(negedge clk);
    reset = 1'b0; ld_en = 1'b0; chk_en = 1'b0;
    req0("rstprio_st", 32'h1C, 32'h7E4, 4'hF, rd);
    chk("rstprio_pass", 32'(pass0), 32'd0);
    chk("rstprio_err",  32'(err0),  32'd1);
    req0("rstprio_rd", 32'h14, 32'd0, 4'h0, rd);
    chk("rstprio_word5", rd, 32'h1111_1111);
    do_reset();

    // Basic read, zero wait states
    preload(10'd2, 32'h0090_0193);
    preload(10'd0, 32'hCAFE_F00D);
    req0("rd08", 32'h08, 32'd0, 4'h0, rd);
    chk("rd08_data", rd, 32'h0090_0193);

    // Single expected store, then an unexpected repeat
    chk_load(3'd0, 32'h1C, 32'h0000_07E4);
    chk("ld1_done", 32'(done0), 32'd0);
    req0("st1c_a", 32'h1C, 32'h0000_07E4, 4'hF, rd);
    chk("st1c_a_pass", 32'(pass0), 32'd1);
    chk("st1c_a_err",  32'(err0),  32'd0);
    chk("st1c_a_done", 32'(done0), 32'd1);
    req0("st1c_b", 32'h1C, 32'h0000_07E4, 4'hF, rd);
    chk("st1c_b_pass", 32'(pass0), 32'd1);
    chk("st1c_b_err",  32'(err0),  32'd1);
    req0("rd1c", 32'h1C, 32'd0, 4'h0, rd);
    chk("rd1c_data", rd, 32'h0000_07E4);

    // Out-of-order stores
    do_reset();
    chk_load(3'd0, 32'h34, 32'h63);
    chk_load(3'd1, 32'h44, 32'h64);
    req0("ord_44", 32'h44, 32'h64, 4'hF, rd);
`ifdef MEMCHK_ANY_ORDER_EN
    chk("ord_44_pass", 32'(pass0), 32'd1);
    chk("ord_44_err",  32'(err0),  32'd0);
`else
    chk("ord_44_pass", 32'(pass0), 32'd0);
    chk("ord_44_err",  32'(err0),  32'd1);
`endif
    req0("ord_34", 32'h34, 32'h63, 4'hF, rd);
`ifndef MEMCHK_ANY_ORDER_EN
    chk("ord_34_pass", 32'(pass0), 32'd1);
    chk("ord_34_done", 32'(done0), 32'd0);
    req0("ord_44b", 32'h44, 32'h64, 4'hF, rd);
    chk("ord_end_err", 32'(err0), 32'd1);
`else
    chk("ord_end_err", 32'(err0), 32'd0);
`endif
    chk("ord_end_pass", 32'(pass0), 32'd2);
    chk("ord_end_done", 32'(done0), 32'd1);

    // Out-of-range accesses; 0x1000 aliases word 0 and must not write it
    req0("oob_rd", 32'h2000, 32'd0, 4'h0, rd);
    chk("oob_rd_data", rd, 32'd0);
    chk("oob_rd_cnt", 32'(oob0), 32'd1);
    req0("oob_st", 32'h1000, 32'hFFFF_FFFF, 4'hF, rd);
    chk("oob_st_data", rd, 32'd0);
    chk("oob_st_cnt", 32'(oob0), 32'd2);
    req0("rd00", 32'h00, 32'd0, 4'h0, rd);
    chk("rd00_data", rd, 32'hCAFE_F00D);

    // Partial store touches only strobed bytes and is not checked
    do_reset();
    preload(10'd33, 32'h4433_2211);
    req0("part", 32'h84, 32'hAABB_CCDD, 4'b0011, rd);
    chk("part_pass", 32'(pass0), 32'd0);
    chk("part_err",  32'(err0),  32'd0);
    chk("part_oob",  32'(oob0),  32'd0);
    req0("rd84", 32'h84, 32'd0, 4'h0, rd);
    chk("rd84_data", rd, 32'h4433_CCDD);

    // Preload wins over a same-cycle core write to the same word
    @(negedge clk);
    v0 = 1'b1; a0 = 32'hA0; d0 = 32'h5555_5555; s0 = 4'hF;
    ld_en = 1'b1; ld_idx = 10'd40; ld_data = 32'h7777_7777;
    @(posedge clk); #1;
    v0 = 1'b0; ld_en = 1'b0;
    chk("coll_ready", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    req0("rdA0", 32'hA0, 32'd0, 4'h0, rd);
    chk("rdA0_data", rd, 32'h7777_7777);

    // Table reload in the same cycle as a check of that entry
    do_reset();
    chk_load(3'd0, 32'h50, 32'h1);
    @(negedge clk);
    v0 = 1'b1; a0 = 32'h50; d0 = 32'h1; s0 = 4'hF;
    chk_en = 1'b1; chk_idx = 3'd0;
    chk_addr = 32'h60; chk_data = 32'h2;
    @(posedge clk); #1;
    v0 = 1'b0; chk_en = 1'b0;
    chk("same_pass", 32'(pass0), 32'd1);
    chk("same_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    req0("same_st60", 32'h60, 32'h2, 4'hF, rd);
    chk("same_st60_pass", 32'(pass0), 32'd2);
    chk("same_st60_done", 32'(done0), 32'd1);

    // Wait states: ready 4 cycles after acceptance, valid toggling ignored
    req3("w3_rd00", 32'h00, 4, 32'hCAFE_F00D);

    // Reset while in WAIT abandons the request
    do_reset();
    chk_load(3'd0, 32'h1C, 32'h7E4);
    @(negedge clk);
    v3 = 1'b1; a3 = 32'h1C; d3 = 32'h7E4; s3 = 4'hF;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rdy3) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("wrst_no_ready", 32'(seen),  32'd0);
    chk("wrst_pass",     32'(pass3), 32'd0);
    chk("wrst_err",      32'(err3),  32'd0);
    chk("wrst_done",     32'(done3), 32'd0);
    req3("wrst_next", 32'h00, 4, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
